// File: rtl/logger_pkg.sv
// Shared width helpers and the FIFO entry layout for the multi-channel averaging logger.
package logger_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_CH   = 4;
   localparam int DEF_AVG_LOG2 = 2;
   localparam int DEF_DEPTH    = 16;

   // Index width for n items; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // The sample counter keeps one bit even when averaging is disabled.
   function automatic int cnt_width(input int avg_log2);
      return (avg_log2 > 0) ? avg_log2 : 1;
   endfunction

   localparam int DEF_CH_W    = idx_width(DEF_NUM_CH);
   localparam int DEF_COUNT_W = idx_width(DEF_DEPTH) + 1;

   // FIFO entry: channel tag in the upper bits, averaged value below.
   typedef struct packed {
      logic [DEF_CH_W-1:0]   ch;
      logic [DEF_DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/logger_fifo.sv
// Synchronous FIFO with registered read port, registered status flags and a flush input.
module logger_fifo
   import logger_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        push,
   input  logic                        pop,
   input  logic [WIDTH-1:0]            din,
   output logic [WIDTH-1:0]            dout,
   output logic                        dout_valid,
   output logic                        full,
   output logic                        empty,
   output logic [idx_width(DEPTH):0]   count
);

   localparam int AW = idx_width(DEPTH);
   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] dout_q;
   logic             do_push, do_pop;

   // A pop while full frees the slot the simultaneous push lands in.
   assign do_pop  = pop && !empty_q && !clear;
   assign do_push = push && (!full_q || do_pop) && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = 1'b0;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
         valid_d = do_pop;
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_V);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

   // Output register holds the last popped entry between pops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         dout_q <= '0;
      else if (do_pop) dout_q <= mem[rd_ptr_q];
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign count      = count_q;

endmodule

// File: rtl/data_logger.sv
// Per-channel block averaging of tagged samples; each completed average is queued in a FIFO.
module data_logger
   import logger_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_CH   = 4,
   parameter int AVG_LOG2 = 2,
   parameter int DEPTH    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        smp_valid,
   input  logic [idx_width(NUM_CH)-1:0] smp_ch,
   input  logic [DATA_W-1:0]           smp_data,
   input  logic                        clear,
   input  logic                        rd_en,
   output logic                        rd_valid,
   output logic [idx_width(NUM_CH)-1:0] rd_ch,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        empty,
   output logic                        full,
   output logic [idx_width(DEPTH):0]   count,
   output logic                        overflow
);

   localparam int CH_W    = idx_width(NUM_CH);
   localparam int ACC_W   = DATA_W + AVG_LOG2;
   localparam int CNT_W   = cnt_width(AVG_LOG2);
   localparam int ENTRY_W = CH_W + DATA_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [CH_W:0]    NUM_CH_V = (CH_W+1)'(NUM_CH);

   logic [NUM_CH*ACC_W-1:0] acc_flat;
   logic [NUM_CH*CNT_W-1:0] cnt_flat;
   logic [ACC_W-1:0]        acc_sel, sum, result_wide;
   logic [CNT_W-1:0]        cnt_sel;
   logic [DATA_W-1:0]       result;
   logic                    ch_ok, accept, last, push;
   logic                    overflow_q, overflow_d;
   logic                    fifo_full;
   logic [ENTRY_W-1:0]      fifo_dout;

   assign ch_ok  = ({1'b0, smp_ch} < NUM_CH_V);
   assign accept = smp_valid && ch_ok && !clear;

   always_comb begin
      acc_sel = '0;
      cnt_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (smp_ch == CH_W'(i)) begin
            acc_sel = acc_flat[i*ACC_W +: ACC_W];
            cnt_sel = cnt_flat[i*CNT_W +: CNT_W];
         end
      end
   end

   // The accumulator is wide enough that the full block sum cannot wrap.
   assign last        = (cnt_sel == CNT_LAST);
   assign push        = accept && last;
   assign sum         = acc_sel + ACC_W'(smp_data);
   assign result_wide = sum >> AVG_LOG2;
   assign result      = result_wide[DATA_W-1:0];

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [ACC_W-1:0] acc_q;
         logic [CNT_W-1:0] cnt_q;
         logic             sel;

         assign sel = accept && (smp_ch == CH_W'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               acc_q <= '0;
               cnt_q <= '0;
            end else if (clear) begin
               acc_q <= '0;
               cnt_q <= '0;
            end else if (sel) begin
               if (last) begin
                  acc_q <= '0;
                  cnt_q <= '0;
               end else begin
                  acc_q <= sum;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end

         assign acc_flat[gi*ACC_W +: ACC_W] = acc_q;
         assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_q;
      end
   endgenerate

   // A result is lost only when the FIFO is full and nothing leaves on that edge.
   always_comb begin
      overflow_d = overflow_q;
      if (clear)                             overflow_d = 1'b0;
      else if (push && fifo_full && !rd_en)  overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

   logger_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .push       (push),
      .pop        (rd_en),
      .din        ({smp_ch, result}),
      .dout       (fifo_dout),
      .dout_valid (rd_valid),
      .full       (fifo_full),
      .empty      (empty),
      .count      (count)
   );

   assign full     = fifo_full;
   assign overflow = overflow_q;
   assign rd_ch    = fifo_dout[ENTRY_W-1 -: CH_W];
   assign rd_data  = fifo_dout[DATA_W-1:0];

endmodule

// File: tb/tb_data_logger.sv
// Checks two logger instances (4-sample averaging, and pass-through with 5 channels) against a queue model.
module tb_data_logger;
   import logger_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       smp_valid = 1'b0;
   logic [2:0] smp_ch = '0;
   logic [7:0] smp_data = '0;
   logic       clear = 1'b0;
   logic       rd_en = 1'b0;

   logic       a_rd_valid, a_empty, a_full, a_overflow;
   logic [1:0] a_rd_ch;
   logic [7:0] a_rd_data;
   logic [4:0] a_count;
   logic       b_rd_valid, b_empty, b_full, b_overflow;
   logic [2:0] b_rd_ch;
   logic [7:0] b_rd_data;
   logic [4:0] b_count;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   data_logger #(.DATA_W(8), .NUM_CH(4), .AVG_LOG2(2), .DEPTH(16)) u_dut_a (
      .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_ch(smp_ch[1:0]), .smp_data(smp_data),
      .clear(clear), .rd_en(rd_en), .rd_valid(a_rd_valid), .rd_ch(a_rd_ch), .rd_data(a_rd_data),
      .empty(a_empty), .full(a_full), .count(a_count), .overflow(a_overflow));

   data_logger #(.DATA_W(8), .NUM_CH(5), .AVG_LOG2(0), .DEPTH(16)) u_dut_b (
      .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
      .clear(clear), .rd_en(rd_en), .rd_valid(b_rd_valid), .rd_ch(b_rd_ch), .rd_data(b_rd_data),
      .empty(b_empty), .full(b_full), .count(b_count), .overflow(b_overflow));

   // Reference model: per-channel running sums and a circular list of queued results.
   int m_sum  [2][8];
   int m_n    [2][8];
   int m_buf  [2][16];
   int m_head [2];
   int m_size [2];
   int m_ovf  [2];
   int m_rdv  [2];
   int m_rdch [2];
   int m_rdd  [2];

   typedef struct {
      bit     v;
      int     ch;
      int     data;
      bit     rd;
      int     e_cnt;
      bit     e_rdv;
      entry_t e_out;
   } vec_t;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endfunction

   function automatic void model_clear(int k);
      for (int c = 0; c < 8; c++) begin
         m_sum[k][c] = 0;
         m_n[k][c]   = 0;
      end
      m_head[k] = 0;
      m_size[k] = 0;
      m_ovf[k]  = 0;
      m_rdv[k]  = 0;
   endfunction

   function automatic void model_edge(int k, bit v, int ch, int data, bit rd, bit clr);
      int navg = (k == 0) ? 4 : 1;
      int nch  = (k == 0) ? 4 : 5;
      int c    = (k == 0) ? ch % 4 : ch % 8;
      int e;
      if (clr) begin
         model_clear(k);
         return;
      end
      m_rdv[k] = 0;
      if (rd && m_size[k] > 0) begin
         e         = m_buf[k][m_head[k]];
         m_head[k] = (m_head[k] + 1) % 16;
         m_size[k]--;
         m_rdv[k]  = 1;
         m_rdch[k] = e / 256;
         m_rdd[k]  = e % 256;
      end
      if (v && c < nch) begin
         m_sum[k][c] += data;
         m_n[k][c]++;
         if (m_n[k][c] == navg) begin
            if (m_size[k] < 16) begin
               m_buf[k][(m_head[k] + m_size[k]) % 16] = c * 256 + m_sum[k][c] / navg;
               m_size[k]++;
            end else begin
               m_ovf[k] = 1;
            end
            m_sum[k][c] = 0;
            m_n[k][c]   = 0;
         end
      end
   endfunction

   function automatic void cmp_inst(string p, int k, logic [4:0] cnt, logic emp, logic ful,
                                    logic ovf, logic rdv, logic [2:0] rch, logic [7:0] rdd);
      chk({p, ".count"},    32'(cnt), 32'(m_size[k]));
      chk({p, ".empty"},    32'(emp), 32'(m_size[k] == 0));
      chk({p, ".full"},     32'(ful), 32'(m_size[k] == 16));
      chk({p, ".overflow"}, 32'(ovf), 32'(m_ovf[k]));
      chk({p, ".rd_valid"}, 32'(rdv), 32'(m_rdv[k]));
      chk({p, ".rd_ch"},    32'(rch), 32'(m_rdch[k]));
      chk({p, ".rd_data"},  32'(rdd), 32'(m_rdd[k]));
   endfunction

   function automatic void cmp_all();
      cmp_inst("A", 0, a_count, a_empty, a_full, a_overflow, a_rd_valid, {1'b0, a_rd_ch}, a_rd_data);
      cmp_inst("B", 1, b_count, b_empty, b_full, b_overflow, b_rd_valid, b_rd_ch, b_rd_data);
   endfunction

   task automatic step(bit v, int ch, int data, bit rd, bit clr);
      smp_valid = v;
      smp_ch    = 3'(ch);
      smp_data  = 8'(data);
      rd_en     = rd;
      clear     = clr;
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_edge(k, v, ch % 8, data % 256, rd, clr);
      #1;
      cyc++;
      cmp_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         model_clear(k);
         m_rdch[k] = 0;
         m_rdd[k]  = 0;
      end
      cmp_all();
      @(posedge clk);
      #1;
      smp_valid = 1'b0;
      rd_en     = 1'b0;
      clear     = 1'b0;
      rst       = 1'b0;
   endtask

   function automatic vec_t mk(bit v, int ch, int d, bit rd, int ec, bit ev, int ech, int ed);
      vec_t r;
      r.v          = v;
      r.ch         = ch;
      r.data       = d;
      r.rd         = rd;
      r.e_cnt      = ec;
      r.e_rdv      = ev;
      r.e_out.ch   = 2'(ech);
      r.e_out.data = 8'(ed);
      return r;
   endfunction

   initial begin
      #200000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[17];
      int   rd_pct;

      tbl[0]  = mk(1, 1, 10,  0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 20,  0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 1, 30,  0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 1, 40,  0, 1, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0,   1, 0, 1, 1, 25);
      tbl[5]  = mk(0, 0, 0,   0, 0, 0, 1, 25);
      tbl[6]  = mk(1, 0, 4,   0, 0, 0, 1, 25);
      tbl[7]  = mk(1, 3, 255, 0, 0, 0, 1, 25);
      tbl[8]  = mk(1, 0, 4,   0, 0, 0, 1, 25);
      tbl[9]  = mk(1, 3, 255, 0, 0, 0, 1, 25);
      tbl[10] = mk(1, 0, 4,   0, 0, 0, 1, 25);
      tbl[11] = mk(1, 3, 255, 0, 0, 0, 1, 25);
      tbl[12] = mk(1, 0, 4,   0, 1, 0, 1, 25);
      tbl[13] = mk(1, 3, 254, 0, 2, 0, 1, 25);
      tbl[14] = mk(0, 0, 0,   1, 1, 1, 0, 4);
      tbl[15] = mk(0, 0, 0,   1, 0, 1, 3, 254);
      tbl[16] = mk(0, 0, 0,   1, 0, 0, 3, 254);

      #1;
      do_reset();

      // Single-channel average, pop latency and hold, then interleaved channels.
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].v, tbl[i].ch, tbl[i].data, tbl[i].rd, 1'b0);
         chk("tbl.count",    32'(a_count),    32'(tbl[i].e_cnt));
         chk("tbl.rd_valid", 32'(a_rd_valid), 32'(tbl[i].e_rdv));
         chk("tbl.rd_ch",    32'(a_rd_ch),    32'(tbl[i].e_out.ch));
         chk("tbl.rd_data",  32'(a_rd_data),  32'(tbl[i].e_out.data));
      end

      // Seventeen results without reads: full after sixteen, the seventeenth dropped.
      step(0, 0, 0, 0, 1);
      for (int j = 0; j < 17; j++) begin
         for (int s = 0; s < 4; s++) step(1, 2, j + 10, 0, 0);
         if (j == 14) chk("fill.full_early", 32'(a_full), 32'd0);
         if (j == 15) begin
            chk("fill.full",      32'(a_full),     32'd1);
            chk("fill.ovf_early", 32'(a_overflow), 32'd0);
         end
      end
      chk("fill.overflow", 32'(a_overflow), 32'd1);
      chk("fill.count",    32'(a_count),    32'd16);
      step(0, 0, 0, 1, 0);
      chk("fill.first_data", 32'(a_rd_data), 32'd10);
      chk("fill.first_ch",   32'(a_rd_ch),   32'd2);

      // Full FIFO with a completing sample and a pop on the same edge.
      step(0, 0, 0, 0, 1);
      for (int j = 0; j < 16; j++)
         for (int s = 0; s < 4; s++) step(1, 1, j + 50, 0, 0);
      chk("pp.full", 32'(a_full), 32'd1);
      for (int s = 0; s < 3; s++) step(1, 1, 99, 0, 0);
      step(1, 1, 99, 1, 0);
      chk("pp.count",    32'(a_count),    32'd16);
      chk("pp.overflow", 32'(a_overflow), 32'd0);
      chk("pp.popped",   32'(a_rd_data),  32'd50);
      for (int j = 0; j < 16; j++) step(0, 0, 0, 1, 0);
      chk("pp.last_data", 32'(a_rd_data), 32'd99);
      chk("pp.last_ch",   32'(a_rd_ch),   32'd1);
      chk("pp.empty",     32'(a_empty),   32'd1);

      // Reset part-way through an average discards the partial sum.
      step(0, 0, 0, 0, 1);
      step(1, 2, 100, 0, 0);
      step(1, 2, 100, 0, 0);
      do_reset();
      for (int s = 0; s < 3; s++) step(1, 2, 8, 0, 0);
      chk("rst.count3", 32'(a_count), 32'd0);
      step(1, 2, 8, 0, 0);
      chk("rst.count4", 32'(a_count), 32'd1);
      step(0, 0, 0, 1, 0);
      chk("rst.rd_ch",   32'(a_rd_ch),   32'd2);
      chk("rst.rd_data", 32'(a_rd_data), 32'd8);

      // Clear wins over a concurrent sample and pop; out-of-range channels are ignored.
      step(1, 0, 1, 0, 0);
      step(1, 5, 77, 1, 1);
      chk("clr.count",    32'(b_count),    32'd0);
      chk("clr.rd_valid", 32'(b_rd_valid), 32'd0);
      step(1, 5, 77, 0, 0);
      step(1, 6, 1, 0, 0);
      step(1, 7, 2, 0, 0);
      chk("oor.count", 32'(b_count), 32'd0);
      step(1, 4, 200, 0, 0);
      chk("pass.count", 32'(b_count), 32'd1);
      step(0, 0, 0, 1, 0);
      chk("pass.rd_ch",   32'(b_rd_ch),   32'd4);
      chk("pass.rd_data", 32'(b_rd_data), 32'd200);

      // Randomized traffic with a slow reader, then a fast reader.
      for (int i = 0; i < 1600; i++) begin
         rd_pct = (i < 800) ? 12 : 66;
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
              $urandom_range(0, 99) < rd_pct, $urandom_range(0, 199) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
